mem_arbiter: RTL and testbench

//  Sequences all traffic into the byte-serial memory controller. Takes fetch requests (icache) and

---
 rtl/mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Sequences all traffic into the byte-serial memory controller. Fetch requests
// (icache) and load/store requests (LSB) are granted one at a time onto the
// controller's IF or LSB port; completions are returned upstream as one-cycle
// done pulses with registered data. After every transaction a one-cycle GAP
// state covers the controller's post-done recovery. Also handles rollback
// squash and IF starvation.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rdy                   global ready; low freezes all state and outputs
//   rollback              misprediction flush
//   if_req/if_addr        fetch request (held until if_done or rollback)
//   if_done/if_data       one-cycle completion pulse with the fetched line
//   ls_req/ls_rw/ls_addr/ls_len/ls_wdata   load/store request (rw=1 store)
//   ls_done/ls_rdata      one-cycle completion pulse with load data
//   mc_if_en/mc_if_pc     controller IF port request
//   mc_if_done/mc_if_data controller IF port completion
//   mc_ls_en/mc_ls_rw/mc_ls_addr/mc_ls_len/mc_ls_wdata  controller LSB port
//   mc_ls_done/mc_ls_rdata controller LSB port completion
//
// Optional build macro MEM_ARBITER_STATS_EN adds stat_if_grants,
// stat_ls_grants and stat_stall_cycles (32-bit wrapping counters).
module mem_arbiter #(
  parameter int STARVE_LIM    = 4,
  parameter int IF_LINE_BYTES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       if_req,
  input  logic [31:0]                if_addr,
  output logic                       if_done,
  output logic [8*IF_LINE_BYTES-1:0] if_data,
  input  logic                       ls_req,
  input  logic                       ls_rw,
  input  logic [31:0]                ls_addr,
  input  logic [2:0]                 ls_len,
  input  logic [31:0]                ls_wdata,
  output logic                       ls_done,
  output logic [31:0]                ls_rdata,
  output logic                       mc_if_en,
  output logic [31:0]                mc_if_pc,
  input  logic                       mc_if_done,
  input  logic [8*IF_LINE_BYTES-1:0] mc_if_data,
  output logic                       mc_ls_en,
  output logic                       mc_ls_rw,
  output logic [31:0]                mc_ls_addr,
  output logic [2:0]                 mc_ls_len,
  output logic [31:0]                mc_ls_wdata,
  input  logic                       mc_ls_done,
  input  logic [31:0]                mc_ls_rdata
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]                stat_if_grants,
  output logic [31:0]                stat_ls_grants,
  output logic [31:0]                stat_stall_cycles
`endif
);

  localparam int                LINE_W = 8 * IF_LINE_BYTES;
  localparam int                CNT_W  = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  LIM_C  = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {S_IDLE, S_IF_BUSY, S_LS_BUSY, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                squash_q, squash_d;
  logic                if_done_q, if_done_d;
  logic [LINE_W-1:0]   if_data_q, if_data_d;
  logic                ls_done_q, ls_done_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;
  logic                mc_if_en_q, mc_if_en_d;
  logic [31:0]         mc_if_pc_q, mc_if_pc_d;
  logic                mc_ls_en_q, mc_ls_en_d;
  logic                mc_ls_rw_q, mc_ls_rw_d;
  logic [31:0]         mc_ls_addr_q, mc_ls_addr_d;
  logic [2:0]          mc_ls_len_q, mc_ls_len_d;
  logic [31:0]         mc_ls_wdata_q, mc_ls_wdata_d;

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    squash_d      = squash_q;
    if_done_d     = if_done_q;
    if_data_d     = if_data_q;
    ls_done_d     = ls_done_q;
    ls_rdata_d    = ls_rdata_q;
    mc_if_en_d    = mc_if_en_q;
    mc_if_pc_d    = mc_if_pc_q;
    mc_ls_en_d    = mc_ls_en_q;
    mc_ls_rw_d    = mc_ls_rw_q;
    mc_ls_addr_d  = mc_ls_addr_q;
    mc_ls_len_d   = mc_ls_len_q;
    mc_ls_wdata_d = mc_ls_wdata_q;

    if (rdy) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rollback) begin
            // LSB wins unless IF has been passed over STARVE_LIM times.
            if (ls_req && (!if_req || starve_cnt_q < LIM_C)) begin
              mc_ls_en_d    = 1'b1;
              mc_ls_rw_d    = ls_rw;
              mc_ls_addr_d  = ls_addr;
              mc_ls_len_d   = ls_len;
              mc_ls_wdata_d = ls_wdata;
              state_d       = S_LS_BUSY;
              if (if_req && starve_cnt_q != LIM_C)
                starve_cnt_d = starve_cnt_q + 1'b1;
            end else if (if_req) begin
              mc_if_en_d   = 1'b1;
              mc_if_pc_d   = if_addr;
              starve_cnt_d = '0;
              state_d      = S_IF_BUSY;
            end
          end
        end
        S_IF_BUSY: begin
          // The controller always finishes a fetch, so a rollback only
          // marks the result as unwanted.
          if (mc_if_done) begin
            mc_if_en_d = 1'b0;
            state_d    = S_GAP;
            if (!squash_q && !rollback) begin
              if_done_d = 1'b1;
              if_data_d = mc_if_data;
            end
          end else if (rollback) begin
            squash_d = 1'b1;
          end
        end
        S_LS_BUSY: begin
          if (mc_ls_done) begin
            mc_ls_en_d = 1'b0;
            state_d    = S_GAP;
            // Stores are committed and survive a rollback; loads do not.
            if (mc_ls_rw_q || !rollback) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = mc_ls_rdata;
            end
          end else if (rollback && !mc_ls_rw_q) begin
            // Controller drops an in-flight load on rollback without a done.
            mc_ls_en_d = 1'b0;
            state_d    = S_GAP;
          end
        end
        S_GAP: begin
          if_done_d = 1'b0;
          ls_done_d = 1'b0;
          squash_d  = 1'b0;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      starve_cnt_q  <= '0;
      squash_q      <= 1'b0;
      if_done_q     <= 1'b0;
      if_data_q     <= '0;
      ls_done_q     <= 1'b0;
      ls_rdata_q    <= '0;
      mc_if_en_q    <= 1'b0;
      mc_if_pc_q    <= '0;
      mc_ls_en_q    <= 1'b0;
      mc_ls_rw_q    <= 1'b0;
      mc_ls_addr_q  <= '0;
      mc_ls_len_q   <= '0;
      mc_ls_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      squash_q      <= squash_d;
      if_done_q     <= if_done_d;
      if_data_q     <= if_data_d;
      ls_done_q     <= ls_done_d;
      ls_rdata_q    <= ls_rdata_d;
      mc_if_en_q    <= mc_if_en_d;
      mc_if_pc_q    <= mc_if_pc_d;
      mc_ls_en_q    <= mc_ls_en_d;
      mc_ls_rw_q    <= mc_ls_rw_d;
      mc_ls_addr_q  <= mc_ls_addr_d;
      mc_ls_len_q   <= mc_ls_len_d;
      mc_ls_wdata_q <= mc_ls_wdata_d;
    end
  end

  assign if_done     = if_done_q;
  assign if_data     = if_data_q;
  assign ls_done     = ls_done_q;
  assign ls_rdata    = ls_rdata_q;
  assign mc_if_en    = mc_if_en_q;
  assign mc_if_pc    = mc_if_pc_q;
  assign mc_ls_en    = mc_ls_en_q;
  assign mc_ls_rw    = mc_ls_rw_q;
  assign mc_ls_addr  = mc_ls_addr_q;
  assign mc_ls_len   = mc_ls_len_q;
  assign mc_ls_wdata = mc_ls_wdata_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] stat_if_q, stat_if_d;
  logic [31:0] stat_ls_q, stat_ls_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_if_d    = stat_if_q;
    stat_ls_d    = stat_ls_q;
    stat_stall_d = stat_stall_q;
    if (rdy) begin
      // Grants are recognised by the IDLE -> BUSY transition.
      if (state_q == S_IDLE && state_d == S_IF_BUSY) stat_if_d = stat_if_q + 32'd1;
      if (state_q == S_IDLE && state_d == S_LS_BUSY) stat_ls_d = stat_ls_q + 32'd1;
      if ((if_req || ls_req) && !(state_q == S_IDLE && !rollback))
        stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_q    <= '0;
      stat_ls_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_if_q    <= stat_if_d;
      stat_ls_q    <= stat_ls_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_if_grants    = stat_if_q;
  assign stat_ls_grants    = stat_ls_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LIM = 4;
  localparam int LB  = 16;

  logic            clk = 0;
  logic            rst_n = 0;
  logic            rdy = 1, rollback = 0;
  logic            if_req = 0;
  logic [31:0]     if_addr = 0;
  logic            if_done;
  logic [8*LB-1:0] if_data;
  logic            ls_req = 0, ls_rw = 0;
  logic [31:0]     ls_addr = 0, ls_wdata = 0;
  logic [2:0]      ls_len = 0;
  logic            ls_done;
  logic [31:0]     ls_rdata;
  logic            mc_if_en;
  logic [31:0]     mc_if_pc;
  logic            mc_if_done = 0;
  logic [8*LB-1:0] mc_if_data = 0;
  logic            mc_ls_en, mc_ls_rw;
  logic [31:0]     mc_ls_addr, mc_ls_wdata;
  logic [2:0]      mc_ls_len;
  logic            mc_ls_done = 0;
  logic [31:0]     mc_ls_rdata = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [263:0] all_out;
  assign all_out = {if_done, if_data, ls_done, ls_rdata, mc_if_en, mc_if_pc, mc_ls_en,
                    mc_ls_rw, mc_ls_addr, mc_ls_len, mc_ls_wdata};

  mem_arbiter #(.STARVE_LIM(LIM), .IF_LINE_BYTES(LB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_if_en(mc_if_en), .mc_if_pc(mc_if_pc), .mc_if_done(mc_if_done), .mc_if_data(mc_if_data),
    .mc_ls_en(mc_ls_en), .mc_ls_rw(mc_ls_rw), .mc_ls_addr(mc_ls_addr), .mc_ls_len(mc_ls_len),
    .mc_ls_wdata(mc_ls_wdata), .mc_ls_done(mc_ls_done), .mc_ls_rdata(mc_ls_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1; rollback = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_rw = 0;
    ls_addr = 0; ls_len = 0; ls_wdata = 0; mc_if_done = 0; mc_ls_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    // Busy inputs during reset must not leak through.
    rst_n = 0; if_req = 1; ls_req = 1; if_addr = 32'h1234; ls_addr = 32'h55;
    mc_if_done = 1; mc_ls_done = 1; mc_ls_rdata = 32'hFFFF_FFFF;
    tick();
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    clear_inputs();
    rst_n = 1;
    ls_req = 1; ls_rw = 1; ls_addr = 32'h3000; ls_len = 3'd4; ls_wdata = 32'hA5A5_0001;
    tick();
    n_tests++;
    if (mc_ls_en !== 1'b1) begin n_fail++; $display("FAIL reset_store_grant: mc_ls_en=%b required 1", mc_ls_en); end
    tick();
    tick();
    rst_n = 0;
    #1;
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_mid_store: got %h required 0", all_out); end
    ls_req = 0;
    tick();
    rst_n = 1;
    mc_ls_done = 1;
    tick();
    tick();
    n_tests++;
    if (ls_done !== 1'b0 || mc_ls_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_ls_done: ls_done=%b mc_ls_en=%b required 0 0", ls_done, mc_ls_en);
    end
    mc_ls_done = 0; if_req = 1; if_addr = 32'h40;
    tick();
    n_tests++;
    if (mc_if_en !== 1'b1 || mc_if_pc !== 32'h40) begin
      n_fail++; $display("FAIL reset_idle_after: mc_if_en=%b pc=%h required 1 00000040", mc_if_en, mc_if_pc);
    end
  endtask

  task automatic test_fetch();
    logic            stable;
    logic [8*LB-1:0] d;
    do_reset();
    if_addr = 32'h100; if_req = 1;
    tick();
    n_tests++;
    if (mc_if_en !== 1'b1 || mc_if_pc !== 32'h100 || mc_ls_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_grant: en=%b pc=%h ls_en=%b required 1 00000100 0", mc_if_en, mc_if_pc, mc_ls_en);
    end
    stable = 1;
    repeat (16) begin
      tick();
      if (mc_if_en !== 1'b1 || mc_if_pc !== 32'h100 || if_done !== 1'b0) stable = 0;
    end
    n_tests++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL fetch_hold: stable=%b required 1", stable); end
    d = {$urandom, $urandom, $urandom, $urandom};
    mc_if_data = d; mc_if_done = 1;
    tick();
    n_tests++;
    if (if_done !== 1'b1 || if_data !== d || mc_if_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_done: done=%b data=%h en=%b required 1 %h 0", if_done, if_data, mc_if_en, d);
    end
    if_req = 0; mc_if_done = 0;
    ls_req = 1; ls_rw = 0; ls_addr = 32'h44; ls_len = 3'd1;
    tick();
    n_tests++;
    if (if_done !== 1'b0 || mc_ls_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_gap: if_done=%b ls_en=%b required 0 0", if_done, mc_ls_en);
    end
    tick();
    n_tests++;
    if (mc_ls_en !== 1'b1 || mc_ls_addr !== 32'h44) begin
      n_fail++; $display("FAIL fetch_after_gap: ls_en=%b addr=%h required 1 00000044", mc_ls_en, mc_ls_addr);
    end
  endtask

  task automatic test_starve();
    int   cnt;
    int   w;
    logic both;
    logic exp_ls;
    do_reset();
    cnt = 0; both = 0;
    if_req = 1; if_addr = 32'h800; ls_req = 1; ls_rw = 0; ls_addr = 32'h900; ls_len = 3'd4;
    for (int g = 0; g < 10; g++) begin
      w = 0;
      do begin
        tick();
        w++;
        if (mc_if_en && mc_ls_en) both = 1;
      end while (!mc_if_en && !mc_ls_en && w < 8);
      if (!mc_if_en && !mc_ls_en) begin
        n_tests++; n_fail++;
        $display("FAIL starve_timeout: no grant %0d within 8 cycles", g);
        break;
      end
      exp_ls = (cnt < LIM);
      if (exp_ls) cnt = cnt + 1; else cnt = 0;
      n_tests++;
      if (mc_ls_en !== exp_ls) begin
        n_fail++; $display("FAIL starve_order[%0d]: ls_en=%b required %b", g, mc_ls_en, exp_ls);
      end
      repeat (2) begin
        tick();
        if (mc_if_en && mc_ls_en) both = 1;
      end
      if (mc_ls_en) mc_ls_done = 1; else mc_if_done = 1;
      tick();
      mc_ls_done = 0; mc_if_done = 0;
    end
    n_tests++;
    if (both !== 1'b0) begin n_fail++; $display("FAIL starve_both_en: seen=%b required 0", both); end
  endtask

  task automatic test_load_rollback();
    do_reset();
    ls_req = 1; ls_rw = 0; ls_addr = 32'h2000; ls_len = 3'd4;
    tick();
    n_tests++;
    if (mc_ls_en !== 1'b1 || mc_ls_addr !== 32'h2000 || mc_ls_len !== 3'd4 || mc_ls_rw !== 1'b0) begin
      n_fail++; $display("FAIL load_grant: en=%b addr=%h len=%0d rw=%b required 1 00002000 4 0",
                         mc_ls_en, mc_ls_addr, mc_ls_len, mc_ls_rw);
    end
    tick();
    tick();
    rollback = 1; ls_req = 0;
    tick();
    n_tests++;
    if (mc_ls_en !== 1'b0 || ls_done !== 1'b0) begin
      n_fail++; $display("FAIL load_abort: en=%b ls_done=%b required 0 0", mc_ls_en, ls_done);
    end
    rollback = 0; if_req = 1; if_addr = 32'h700;
    tick();
    n_tests++;
    if (mc_if_en !== 1'b0 || mc_ls_en !== 1'b0 || ls_done !== 1'b0) begin
      n_fail++; $display("FAIL load_gap: if_en=%b ls_en=%b ls_done=%b required 0 0 0", mc_if_en, mc_ls_en, ls_done);
    end
    tick();
    n_tests++;
    if (mc_if_en !== 1'b1 || mc_if_pc !== 32'h700) begin
      n_fail++; $display("FAIL load_next_grant: en=%b pc=%h required 1 00000700", mc_if_en, mc_if_pc);
    end
  endtask

  task automatic test_store_rollback();
    int pulses;
    do_reset();
    ls_req = 1; ls_rw = 1; ls_addr = 32'h3000; ls_len = 3'd4; ls_wdata = 32'hDEADBEEF;
    tick();
    n_tests++;
    if (mc_ls_en !== 1'b1 || mc_ls_rw !== 1'b1 || mc_ls_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_grant: en=%b rw=%b wdata=%h required 1 1 deadbeef", mc_ls_en, mc_ls_rw, mc_ls_wdata);
    end
    tick();
    rollback = 1;
    tick();
    rollback = 0;
    n_tests++;
    if (mc_ls_en !== 1'b1 || ls_done !== 1'b0 || mc_ls_addr !== 32'h3000) begin
      n_fail++; $display("FAIL store_survives: en=%b done=%b addr=%h required 1 0 00003000", mc_ls_en, ls_done, mc_ls_addr);
    end
    tick();
    mc_ls_done = 1;
    tick();
    mc_ls_done = 0; ls_req = 0;
    pulses = ls_done ? 1 : 0;
    repeat (4) begin
      tick();
      if (ls_done) pulses++;
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL store_pulse_count: got %0d required 1", pulses); end
    ls_req = 1; ls_addr = 32'h3004; ls_wdata = 32'h0BADF00D;
    tick();
    mc_ls_done = 1; rollback = 1;
    tick();
    mc_ls_done = 0; rollback = 0; ls_req = 0;
    n_tests++;
    if (ls_done !== 1'b1 || mc_ls_en !== 1'b0) begin
      n_fail++; $display("FAIL store_done_with_rollback: done=%b en=%b required 1 0", ls_done, mc_ls_en);
    end
  endtask

  task automatic test_fetch_rollback();
    logic            ok;
    logic [8*LB-1:0] d;
    do_reset();
    if_req = 1; if_addr = 32'h400;
    tick();
    tick();
    rollback = 1; if_req = 0;
    tick();
    rollback = 0;
    n_tests++;
    if (mc_if_en !== 1'b1) begin n_fail++; $display("FAIL fetch_rb_wait: en=%b required 1", mc_if_en); end
    if_req = 1; if_addr = 32'h500;
    ok = 1;
    repeat (3) begin
      tick();
      if (mc_if_en !== 1'b1 || mc_if_pc !== 32'h400 || if_done !== 1'b0) ok = 0;
    end
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL fetch_rb_hold: ok=%b required 1", ok); end
    mc_if_data = {$urandom, $urandom, $urandom, $urandom}; mc_if_done = 1;
    tick();
    mc_if_done = 0;
    n_tests++;
    if (if_done !== 1'b0 || mc_if_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rb_squash: done=%b en=%b required 0 0", if_done, mc_if_en);
    end
    tick();
    n_tests++;
    if (mc_if_en !== 1'b0 || if_done !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rb_gap: en=%b done=%b required 0 0", mc_if_en, if_done);
    end
    tick();
    n_tests++;
    if (mc_if_en !== 1'b1 || mc_if_pc !== 32'h500) begin
      n_fail++; $display("FAIL fetch_rb_regrant: en=%b pc=%h required 1 00000500", mc_if_en, mc_if_pc);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    mc_if_data = d; mc_if_done = 1;
    tick();
    mc_if_done = 0; if_req = 0;
    n_tests++;
    if (if_done !== 1'b1 || if_data !== d) begin
      n_fail++; $display("FAIL fetch_rb_next_done: done=%b data=%h required 1 %h", if_done, if_data, d);
    end
  endtask

  // Transaction-level model: each round the pending requests compete under
  // the starvation rule, the bench plays the controller with random latency,
  // random rdy stalls, spurious done noise and occasional rollback, and the
  // expected upstream outcome follows from the request kind.
  task automatic test_random();
    logic            pend_if, pend_ls, q_ls_rw;
    logic [31:0]     q_if_addr, q_ls_addr, q_ls_wdata;
    logic [2:0]      q_ls_len;
    int              cnt;
    pend_if = 0; pend_ls = 0; q_ls_rw = 0; q_if_addr = 0; q_ls_addr = 0;
    q_ls_wdata = 0; q_ls_len = 3'd1; cnt = 0;
    do_reset();
    for (int r = 0; r < 60; r++) begin
      logic            exp_ls, squashed, finished, exp_done, exp_en, rr, own, rb;
      int              lat, rb_at, n, guard;
      logic [8*LB-1:0] d_if;
      logic [31:0]     d_ls;
      if (!pend_if && $urandom_range(0, 1) == 1) begin pend_if = 1; q_if_addr = $urandom; end
      if (!pend_ls && (!pend_if || $urandom_range(0, 1) == 1)) begin
        pend_ls = 1; q_ls_rw = 1'($urandom_range(0, 1)); q_ls_addr = $urandom; q_ls_wdata = $urandom;
        case ($urandom_range(0, 2))
          0:       q_ls_len = 3'd1;
          1:       q_ls_len = 3'd2;
          default: q_ls_len = 3'd4;
        endcase
      end
      if_req = pend_if; if_addr = q_if_addr;
      ls_req = pend_ls; ls_rw = q_ls_rw; ls_addr = q_ls_addr; ls_len = q_ls_len; ls_wdata = q_ls_wdata;
      exp_ls = pend_ls && (!pend_if || cnt < LIM);
      if (exp_ls) begin
        if (pend_if && cnt < LIM) cnt++;
      end else begin
        cnt = 0;
      end
      tick();
      n_tests++;
      if (mc_ls_en !== exp_ls || mc_if_en !== !exp_ls ||
          (exp_ls ? ({mc_ls_rw, mc_ls_addr, mc_ls_len, mc_ls_wdata} !== {q_ls_rw, q_ls_addr, q_ls_len, q_ls_wdata})
                  : (mc_if_pc !== q_if_addr))) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: ls_en=%b if_en=%b pc=%h addr=%h required ls_en=%b pc=%h addr=%h",
                 r, mc_ls_en, mc_if_en, mc_if_pc, mc_ls_addr, exp_ls, q_if_addr, q_ls_addr);
      end
      lat = int'($urandom_range(0, 4));
      rb_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat)) : -1;
      d_if = {$urandom, $urandom, $urandom, $urandom};
      d_ls = $urandom;
      mc_if_data = d_if; mc_ls_rdata = d_ls;
      squashed = 0; finished = 0; n = 0; guard = 0;
      while (!finished && guard < 100) begin
        rr  = ($urandom_range(0, 3) != 0);
        rb  = rr && (n == rb_at);
        own = rr ? (n == lat) : 1'($urandom_range(0, 1));
        rdy = rr; rollback = rb;
        if (exp_ls) begin mc_ls_done = own; mc_if_done = 1'($urandom_range(0, 1)); end
        else begin mc_if_done = own; mc_ls_done = 1'($urandom_range(0, 1)); end
        if (rb) begin
          pend_if = 0; if_req = 0;
          if (!(exp_ls && q_ls_rw)) begin pend_ls = 0; ls_req = 0; end
        end
        exp_done = 0; exp_en = 1;
        if (rr) begin
          if (own) begin
            exp_en = 0; finished = 1;
            exp_done = exp_ls ? (q_ls_rw || !rb) : (!squashed && !rb);
          end else if (rb) begin
            if (exp_ls && !q_ls_rw) begin exp_en = 0; finished = 1; end
            else if (!exp_ls) squashed = 1;
          end
          n++;
        end
        tick();
        guard++;
        n_tests++;
        if ((exp_ls ? mc_ls_en : mc_if_en) !== exp_en || (exp_ls ? mc_if_en : mc_ls_en) !== 1'b0 ||
            if_done !== (!exp_ls && exp_done) || ls_done !== (exp_ls && exp_done) ||
            (exp_done && !exp_ls && if_data !== d_if) ||
            (exp_done && exp_ls && !q_ls_rw && ls_rdata !== d_ls)) begin
          n_fail++;
          $display("FAIL rand_busy[%0d]: if_en=%b ls_en=%b if_done=%b ls_done=%b rdata=%h required en=%b done=%b ls=%b rdata=%h",
                   r, mc_if_en, mc_ls_en, if_done, ls_done, ls_rdata, exp_en, exp_done, exp_ls, d_ls);
        end
      end
      if (!finished) begin
        n_tests++; n_fail++;
        $display("FAIL rand_timeout[%0d]: transaction not finished within 100 cycles", r);
      end
      if (exp_ls) pend_ls = 0; else pend_if = 0;
      rdy = 1; rollback = 0; mc_if_done = 0; mc_ls_done = 0;
      if_req = pend_if; ls_req = pend_ls;
      tick();
      n_tests++;
      if (if_done !== 1'b0 || ls_done !== 1'b0 || mc_if_en !== 1'b0 || mc_ls_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_gap[%0d]: if_done=%b ls_done=%b if_en=%b ls_en=%b required 0 0 0 0",
                 r, if_done, ls_done, mc_if_en, mc_ls_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starve();
    test_load_rollback();
    test_store_rollback();
    test_fetch_rollback();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
